lpif_txrx_x8_q2_master_link: RTL

//  Master-end LPIF x8 quarter-rate txrx adapter; mirror of the slave-end packer.

---
 rtl/lpif_txrx_x8_q2_master_link.sv | 119 +++++++++++
 1 files changed

// File: rtl/lpif_txrx_x8_q2_master_link.sv
// Master-end LPIF x8 quarter-rate adapter: packs downstream LPIF fields into
// logic-link words through a 2-entry skid buffer and unpacks upstream words.
module lpif_txrx_x8_q2_master_link #(
  parameter int LLW   = 537,
  parameter int CNT_W = 16
) (
  input  logic             clk_wr,
  input  logic             rst_wr_n,
  input  logic             link_up,
  input  logic             dstrm_push,
  output logic             dstrm_ready,
  input  logic [3:0]       dstrm_state,
  input  logic [1:0]       dstrm_protid,
  input  logic [511:0]     dstrm_data,
  input  logic             dstrm_dvalid,
  input  logic             dstrm_crc_valid,
  input  logic [15:0]      dstrm_crc,
  input  logic             dstrm_valid,
  output logic [LLW-1:0]   txfifo_downstream_data,
  output logic             txfifo_downstream_valid,
  input  logic             txfifo_downstream_ready,
  input  logic [LLW-1:0]   rxfifo_upstream_data,
  input  logic             rxfifo_upstream_valid,
  output logic [3:0]       ustrm_state,
  output logic [1:0]       ustrm_protid,
  output logic [511:0]     ustrm_data,
  output logic             ustrm_dvalid,
  output logic [15:0]      ustrm_crc,
  output logic             ustrm_crc_valid,
  output logic             ustrm_valid,
  output logic             ustrm_state_chg,
  output logic [CNT_W-1:0] tx_word_cnt,
  output logic             rx_proto_err
);

  logic [LLW-1:0] r_mem [2];
  logic           r_head;
  logic [1:0]     r_cnt;
  logic [CNT_W-1:0] r_tx_cnt;

  logic [LLW-1:0] w_in_word;
  logic           w_ready;
  logic           w_valid;
  logic           w_push;
  logic           w_pop;
  logic           w_wr_idx;

  assign w_in_word = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                      dstrm_data, dstrm_protid, dstrm_state};

  // Ready depends only on registered count and link_up, never on the FIFO ready.
  assign w_ready  = link_up & (r_cnt != 2'd2);
  assign w_valid  = link_up & (r_cnt != 2'd0);
  assign w_push   = dstrm_push & w_ready;
  assign w_pop    = w_valid & txfifo_downstream_ready;
  assign w_wr_idx = r_head ^ r_cnt[0];

  assign dstrm_ready             = w_ready;
  assign txfifo_downstream_valid = w_valid;
  assign txfifo_downstream_data  = r_mem[r_head];
  assign tx_word_cnt             = r_tx_cnt;

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_cnt    <= '0;
    end else if (!link_up) begin
      r_head <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_mem[w_wr_idx] <= w_in_word;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n)  r_tx_cnt <= '0;
    else if (w_pop) r_tx_cnt <= r_tx_cnt + 1'b1;
  end

  // Payload fields hold across idle cycles; only the qualifier bits drop.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      ustrm_state     <= 4'h0;
      ustrm_protid    <= '0;
      ustrm_data      <= '0;
      ustrm_dvalid    <= 1'b0;
      ustrm_crc       <= '0;
      ustrm_crc_valid <= 1'b0;
      ustrm_valid     <= 1'b0;
      ustrm_state_chg <= 1'b0;
      rx_proto_err    <= 1'b0;
    end else if (rxfifo_upstream_valid) begin
      ustrm_state     <= rxfifo_upstream_data[3:0];
      ustrm_protid    <= rxfifo_upstream_data[5:4];
      ustrm_data      <= rxfifo_upstream_data[517:6];
      ustrm_dvalid    <= rxfifo_upstream_data[518];
      ustrm_crc       <= rxfifo_upstream_data[534:519];
      ustrm_crc_valid <= rxfifo_upstream_data[535];
      ustrm_valid     <= rxfifo_upstream_data[536];
      ustrm_state_chg <= (rxfifo_upstream_data[3:0] != ustrm_state);
      if (rxfifo_upstream_data[518] && !rxfifo_upstream_data[536])
        rx_proto_err <= 1'b1;
    end else begin
      ustrm_dvalid    <= 1'b0;
      ustrm_crc_valid <= 1'b0;
      ustrm_valid     <= 1'b0;
      ustrm_state_chg <= 1'b0;
    end
  end

endmodule
